load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// Core-side initiator for the data memory port: accepts one load/store request
// at a time from the execute stage, checks it, drives write_mem/funct3/address/data
// onto the data memory, waits out the one-cycle registered read, and returns a single
// rsp_valid pulse with load data or a fault code. Sits between the RV32I pipeline
// and the byte-lane data memory/MMIO block. Sign/zero extension is done in memory.
// PARAMETERS
// RAM_ADDR_BITS  13  RAM window is addr[31:RAM_ADDR_BITS]==0; MMIO window is addr[31:RAM_ADDR_BITS]==all-ones
// PORTS
// clk                input   1   system clock, all state on posedge
// rst                input   1   asynchronous reset, active-high
// req_valid          input   1   request present
// req_ready          output  1   unit can accept; high only in IDLE and rst low
// req_is_store       input   1   1=store, 0=load
// req_funct3         input   3   RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
// req_addr           input  32   byte address
// req_wdata          input  32   store data, bytes right-aligned
// rsp_valid          output  1   one-cycle completion pulse
// rsp_data           output 32   load result (0 for stores/faults); held until next rsp_valid
// rsp_fault          output  1   request faulted, no memory access made
// rsp_cause          output  2   01 misaligned, 10 access (hole), 11 illegal funct3, 00 none
// write_mem          output  1   memory write strobe
// funct3             output  3   size/sign to memory
// write_address      output 32   memory write address
// write_data         output 32   memory write data
// read_address       output 32   memory read address
// read_data          input  32   memory read data, valid 1 cycle after read_address is sampled
// BEHAVIOUR
// - Reset: state IDLE; rsp_valid, rsp_fault, write_mem 0; rsp_cause 2'b00; rsp_data,
//   funct3, write/read_address, write_data all 0. Reset mid-operation aborts instantly:
//   write_mem drops asynchronously, no rsp_valid is issued for the aborted request.
// - Handshake: accept when req_valid & req_ready at posedge; latch is_store/funct3/addr/wdata.
//   Request fields are ignored when not accepted.
// - Checks at accept, priority illegal > misaligned > access:
//   illegal = load funct3 in {011,110,111} or store funct3 not in {000,001,010};
//   misaligned = half & addr[0], or word & addr[1:0]!=0; access = addr neither RAM nor MMIO.
//   Faulted request -> RESP next cycle, no write_mem, no read.
// - FSM: IDLE -> STORE | LOAD | RESP(fault); STORE -> RESP; LOAD -> LOAD_WAIT -> RESP; RESP -> IDLE.
// - STORE: write_mem=1 for exactly one cycle, decoded from state register; address/data/funct3
//   from latched regs.
// - LOAD: read_address/funct3 driven from latch; memory samples them at end of LOAD.
//   LOAD_WAIT: read_data valid; captured into rsp_data at end of LOAD_WAIT.
// - RESP: rsp_valid=1 one cycle; rsp_fault/rsp_cause valid with it; req_ready 0.
// - Latency accept-edge to rsp_valid: fault 1, store 2, load 3 cycles.
//   Back-to-back throughput: one request per 3 (store) / 4 (load) cycles.
// - Address/funct3/data outputs stay at last latched values outside STORE/LOAD; only write_mem qualifies writes.
// - Stores drive write_data = req_wdata unshifted; memory performs lane steering.
// TESTING
// - SW addr 0x100 data 0xDEADBEEF -> write_mem high 1 cycle with addr 0x100, funct3 010; rsp_valid 2 cycles later, fault 0.
// - Then LW 0x100 -> rsp_data 0xDEADBEEF 3 cycles after accept; LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE.
// - LH 0x101 -> rsp_fault 1, cause 01, rsp_valid 1 cycle after accept, write_mem never set.
// - LW 0x00010000 -> cause 10; load funct3 011 -> cause 11; SW 0xFFFFFFFC (LED reg) accepted, no fault.
// - req_valid held high continuously -> req_ready low in STORE/LOAD/LOAD_WAIT/RESP; exactly one accept per transaction.
// - Assert rst during STORE cycle -> write_mem falls immediately, state IDLE, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding initiator between the RV32I execute stage
// and the byte-lane data memory / MMIO block. A request is checked at accept.
// A good request drives one write strobe (store) or one registered read (load).
// A bad request skips memory entirely. Every accepted request ends in exactly
// one rsp_valid pulse.
module load_store_unit #(
    parameter int RAM_ADDR_BITS = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_fault,
    output logic [1:0]  rsp_cause,
    output logic        write_mem,
    output logic [2:0]  funct3,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic [31:0] read_address,
    input  logic [31:0] read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD,
        S_LOAD_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_ACCESS    = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL   = 2'b11;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [1:0]  rsp_cause_q, rsp_cause_d;

    logic        accept;
    logic        illegal, misaligned, access_err;
    logic [1:0]  chk_cause;
    logic [31-RAM_ADDR_BITS:0] addr_hi;

    // Request checks on the incoming request, evaluated combinationally so the
    // fault decision is made on the accept edge itself.
    always_comb begin
        addr_hi    = req_addr[31:RAM_ADDR_BITS];
        illegal    = 1'b0;
        misaligned = 1'b0;
        access_err = !((addr_hi == '0) || (&addr_hi));
        if (req_is_store) begin
            illegal = (req_funct3[2] == 1'b1) || (req_funct3[1:0] == 2'b11);
        end else begin
            illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111);
        end
        // funct3[1:0] gives access size for both loads and stores once legal.
        if (req_funct3[1:0] == 2'b01) begin
            misaligned = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            misaligned = (req_addr[1:0] != 2'b00);
        end
        if (illegal) begin
            chk_cause = CAUSE_ILLEGAL;
        end else if (misaligned) begin
            chk_cause = CAUSE_MISALIGN;
        end else if (access_err) begin
            chk_cause = CAUSE_ACCESS;
        end else begin
            chk_cause = CAUSE_NONE;
        end
    end

    // Ready is gated by rst as well so nothing can be accepted while reset is held.
    assign req_ready = (state_q == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Next-state, request latch and response register updates.
    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        rsp_cause_d = rsp_cause_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (chk_cause != CAUSE_NONE) begin
                        // Response fields change only on entry to RESP, so the
                        // previous result stays visible until this pulse.
                        state_d     = S_RESP;
                        rsp_data_d  = 32'h0;
                        rsp_fault_d = 1'b1;
                        rsp_cause_d = chk_cause;
                    end else if (req_is_store) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_STORE: begin
                state_d     = S_RESP;
                rsp_data_d  = 32'h0;
                rsp_fault_d = 1'b0;
                rsp_cause_d = CAUSE_NONE;
            end
            S_LOAD: begin
                state_d = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                state_d     = S_RESP;
                rsp_data_d  = read_data;
                rsp_fault_d = 1'b0;
                rsp_cause_d = CAUSE_NONE;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_data_q  <= 32'h0;
            rsp_fault_q <= 1'b0;
            rsp_cause_q <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_cause_q <= rsp_cause_d;
        end
    end

    // Strobes decode straight from the state register. write_mem therefore
    // falls as soon as an asynchronous reset clears the state.
    assign write_mem     = (state_q == S_STORE);
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_data      = rsp_data_q;
    assign rsp_fault     = rsp_fault_q;
    assign rsp_cause     = rsp_cause_q;
    assign funct3        = funct3_q;
    assign write_address = addr_q;
    assign read_address  = addr_q;
    assign write_data    = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural byte-lane data
// memory (registered read, sign/zero extension in memory) and a scoreboard queue.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic [1:0]  rsp_cause;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_address;
    logic [31:0] read_data;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   fails = 0;
    int   wm_cnt = 0;
    int   rsp_cnt = 0;
    logic [31:0] wm_addr = 32'h0;
    logic [31:0] wm_data = 32'h0;
    logic [2:0]  wm_f3 = 3'b000;

    logic [7:0]  mem [0:8191];
    logic [31:0] rd_q = 32'h0;

    load_store_unit #(.RAM_ADDR_BITS(13)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
        .rsp_cause(rsp_cause), .write_mem(write_mem), .funct3(funct3),
        .write_address(write_address), .write_data(write_data),
        .read_address(read_address), .read_data(read_data)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f);
        logic [12:0] i;
        logic [7:0]  b;
        logic [15:0] h;
        i = a[12:0];
        b = mem[i];
        h = {mem[i + 13'd1], mem[i]};
        case (f[1:0])
            2'b00:   mem_rd = f[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   mem_rd = f[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: mem_rd = {mem[i + 13'd3], mem[i + 13'd2], h};
        endcase
    endfunction

    // Data memory: lane-steered writes to the RAM window, one-cycle registered read.
    always @(posedge clk) begin
        if (write_mem && write_address[31:13] == 19'h0) begin
            mem[write_address[12:0]] <= write_data[7:0];
            if (funct3[1:0] != 2'b00) mem[write_address[12:0] + 13'd1] <= write_data[15:8];
            if (funct3[1:0] == 2'b10) begin
                mem[write_address[12:0] + 13'd2] <= write_data[23:16];
                mem[write_address[12:0] + 13'd3] <= write_data[31:24];
            end
        end
        rd_q <= mem_rd(read_address, funct3);
    end
    assign read_data = rd_q;

    // Strobe monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (write_mem) begin
            wm_cnt  = wm_cnt + 1;
            wm_addr = write_address;
            wm_data = write_data;
            wm_f3   = funct3;
        end
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    end

    task automatic push_exp(input logic [31:0] d, input logic f, input logic [1:0] c);
        exp_t e;
        e.data = d; e.fault = f; e.cause = c;
        exp_q.push_back(e);
    endtask

    // Drive one request and wait (bounded) for its response; lat = -1 on timeout.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] d,
                          output logic f, output logic [1:0] c);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom;
        req_wdata = $urandom;
        lat = -1; d = 32'h0; f = 1'b0; c = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i; d = rsp_data; f = rsp_fault; c = rsp_cause;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({req_ready, rsp_valid, write_mem, rsp_fault} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 0000", {req_ready, rsp_valid, write_mem, rsp_fault});
        end
        tests_run++;
        if ({rsp_data, rsp_cause, funct3, write_address, write_data, read_address} !== '0) begin
            fails++;
            $display("FAIL reset_data got data=%h cause=%b f3=%b wa=%h wd=%h ra=%h want all 0",
                     rsp_data, rsp_cause, funct3, write_address, write_data, read_address);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset got %b want 1", req_ready);
        end
    endtask

    task automatic test_store();
        int lat; logic [31:0] d; logic f; logic [1:0] c; exp_t e; int wm0;
        wm0 = wm_cnt;
        push_exp(32'h0, 1'b0, 2'b00);
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, d, f, c);
        e = exp_q.pop_front();
        tests_run++;
        if (lat !== 2) begin fails++; $display("FAIL sw_latency got %0d want 2", lat); end
        tests_run++;
        if ({d, f, c} !== {e.data, e.fault, e.cause}) begin
            fails++; $display("FAIL sw_rsp got %h/%b/%b want %h/%b/%b", d, f, c, e.data, e.fault, e.cause);
        end
        tests_run++;
        if ((wm_cnt - wm0) !== 1) begin fails++; $display("FAIL sw_strobe_cycles got %0d want 1", wm_cnt - wm0); end
        tests_run++;
        if ({wm_addr, wm_f3, wm_data} !== {32'h100, 3'b010, 32'hDEADBEEF}) begin
            fails++; $display("FAIL sw_bus got a=%h f3=%b d=%h want 100/010/deadbeef", wm_addr, wm_f3, wm_data);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [5] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exd [5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};
        int lat; logic [31:0] d; logic f; logic [1:0] c; exp_t e; int wm0;
        wm0 = wm_cnt;
        for (int k = 0; k < 5; k++) begin
            push_exp(exd[k], 1'b0, 2'b00);
            do_req(1'b0, f3s[k], ads[k], 32'h0, lat, d, f, c);
            e = exp_q.pop_front();
            tests_run++;
            if (lat !== 3) begin fails++; $display("FAIL load%0d_latency got %0d want 3", k, lat); end
            tests_run++;
            if ({d, f, c} !== {e.data, e.fault, e.cause}) begin
                fails++; $display("FAIL load%0d_rsp got %h/%b/%b want %h/%b/%b", k, d, f, c, e.data, e.fault, e.cause);
            end
        end
        tests_run++;
        if (wm_cnt !== wm0) begin fails++; $display("FAIL load_no_write got %0d strobes want 0", wm_cnt - wm0); end
    endtask

    task automatic test_faults();
        logic        sts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b111, 3'b010};
        logic [31:0] ads [6] = '{32'h101, 32'h00010000, 32'h100, 32'h100, 32'h00010001, 32'h00010002};
        logic [1:0]  cau [6] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
        int lat; logic [31:0] d; logic f; logic [1:0] c; exp_t e; int wm0;
        wm0 = wm_cnt;
        for (int k = 0; k < 6; k++) begin
            push_exp(32'h0, 1'b1, cau[k]);
            do_req(sts[k], f3s[k], ads[k], 32'h12345678, lat, d, f, c);
            e = exp_q.pop_front();
            tests_run++;
            if (lat !== 1) begin fails++; $display("FAIL fault%0d_latency got %0d want 1", k, lat); end
            tests_run++;
            if ({d, f, c} !== {e.data, e.fault, e.cause}) begin
                fails++; $display("FAIL fault%0d_rsp got %h/%b/%b want %h/%b/%b", k, d, f, c, e.data, e.fault, e.cause);
            end
        end
        tests_run++;
        if (wm_cnt !== wm0) begin fails++; $display("FAIL fault_no_write got %0d strobes want 0", wm_cnt - wm0); end
    endtask

    task automatic test_mmio();
        int lat; logic [31:0] d; logic f; logic [1:0] c; exp_t e; int wm0;
        wm0 = wm_cnt;
        push_exp(32'h0, 1'b0, 2'b00);
        do_req(1'b1, 3'b010, 32'hFFFFFFFC, 32'h0000005A, lat, d, f, c);
        e = exp_q.pop_front();
        tests_run++;
        if ({lat, d, f, c} !== {32'd2, e.data, e.fault, e.cause}) begin
            fails++; $display("FAIL mmio_sw got lat=%0d %h/%b/%b want 2 %h/%b/%b", lat, d, f, c, e.data, e.fault, e.cause);
        end
        tests_run++;
        if ((wm_cnt - wm0) !== 1 || wm_addr !== 32'hFFFFFFFC) begin
            fails++; $display("FAIL mmio_strobe got cnt=%0d a=%h want 1/fffffffc", wm_cnt - wm0, wm_addr);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            int acc = 0; int rsp = 0; int want;
            exp_t e;
            want = (k == 0) ? 4 : 3;
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                if (n == 0) begin
                    req_valid = 1'b1; req_is_store = (k == 0);
                    req_funct3 = 3'b010;
                    req_addr = (k == 0) ? 32'h200 : 32'h100;
                    req_wdata = 32'hA5A5A5A5;
                end
                if (req_ready) begin
                    acc++;
                    push_exp((k == 0) ? 32'h0 : 32'hDEADBEEF, 1'b0, 2'b00);
                end
                if (rsp_valid) begin
                    rsp++;
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        fails++; $display("FAIL b2b%0d_extra_rsp got rsp with empty queue want none", k);
                    end else begin
                        e = exp_q.pop_front();
                        if ({rsp_data, rsp_fault, rsp_cause} !== {e.data, e.fault, e.cause}) begin
                            fails++; $display("FAIL b2b%0d_rsp got %h/%b/%b want %h/%b/%b",
                                              k, rsp_data, rsp_fault, rsp_cause, e.data, e.fault, e.cause);
                        end
                    end
                end
                if (n == 11) req_valid = 1'b0;
            end
            tests_run++;
            if (acc !== want || rsp !== want) begin
                fails++; $display("FAIL b2b%0d_count got acc=%0d rsp=%0d want %0d", k, acc, rsp, want);
            end
            tests_run++;
            if (exp_q.size() !== 0) begin
                fails++; $display("FAIL b2b%0d_pending got %0d want 0", k, exp_q.size());
            end
            exp_q.delete();
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] d; logic f; logic [1:0] c; exp_t e; int r0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h104; req_wdata = 32'h11111111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        tests_run++;
        if (write_mem !== 1'b1) begin fails++; $display("FAIL abort_pre_strobe got %b want 1", write_mem); end
        r0 = rsp_cnt;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({write_mem, req_ready, rsp_data} !== {1'b0, 1'b0, 32'h0}) begin
            fails++; $display("FAIL abort_async got wm=%b rdy=%b data=%h want 0/0/0", write_mem, req_ready, rsp_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (rsp_cnt !== r0) begin fails++; $display("FAIL abort_no_rsp got %0d pulses want 0", rsp_cnt - r0); end
        push_exp(32'h0, 1'b0, 2'b00);
        do_req(1'b0, 3'b010, 32'h104, 32'h0, lat, d, f, c);
        e = exp_q.pop_front();
        tests_run++;
        if ({lat, d, f, c} !== {32'd3, e.data, e.fault, e.cause}) begin
            fails++; $display("FAIL abort_mem_untouched got lat=%0d %h want 3 %h", lat, d, e.data);
        end
        push_exp(32'h0, 1'b0, 2'b00);
        do_req(1'b1, 3'b010, 32'h104, 32'hCAFEF00D, lat, d, f, c);
        e = exp_q.pop_front();
        tests_run++;
        if ({lat, d, f, c} !== {32'd2, e.data, e.fault, e.cause}) begin
            fails++; $display("FAIL post_abort_sw got lat=%0d %h/%b/%b want 2 %h", lat, d, f, c, e.data);
        end
        push_exp(32'hCAFEF00D, 1'b0, 2'b00);
        do_req(1'b0, 3'b010, 32'h104, 32'h0, lat, d, f, c);
        e = exp_q.pop_front();
        tests_run++;
        if ({lat, d, f, c} !== {32'd3, e.data, e.fault, e.cause}) begin
            fails++; $display("FAIL post_abort_lw got lat=%0d %h want 3 %h", lat, d, e.data);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_loads();
        test_faults();
        test_mmio();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
